img2col_window_sequencer: RTL and testbench

- Top-level sequencer for the img2col processing-unit datapath.
- Steps a KxK window over an IMG_W x IMG_H feature map, column by column, row by row.
- Drives each PU's per-column group-buffer writes, read strobes and round flag.
- Hands each completed window to the downstream MAC array over a valid/ready handshake, and reports frame done.

---
 rtl/img2col_pkg.sv | 26 ++
 rtl/img2col_win_counter.sv | 43 ++++
 rtl/img2col_window_sequencer.sv | 142 ++++++++++++++
 tb/tb_img2col_window_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/img2col_pkg.sv
// rtl/img2col_pkg.sv - shared types, widths and helpers for the img2col window sequencer
//   Contents: state_t (sequencer FSM states), DATA_W, out_dim() for window counts,
//   idx_w() for index widths that stay at least one bit wide.
package img2col_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    EMIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Number of valid window positions along one image axis.
  function automatic int out_dim(input int img, input int k);
    return img - k + 1;
  endfunction

  // Index width for n positions; a single position still gets a 1-bit port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/img2col_win_counter.sv
// rtl/img2col_win_counter.sv - saturating window row/column position counter
//   Ports: clk, nrst (async active-low); clr zeroes both indices; col_inc advances the
//   column; row_inc advances the row and returns the column to 0; col/row are the
//   current indices; last_col/last_row flag the terminal positions.
module img2col_win_counter
  import img2col_pkg::*;
#(
  parameter int N_COL = 24,
  parameter int N_ROW = 24,
  parameter int COL_W = idx_w(N_COL),
  parameter int ROW_W = idx_w(N_ROW)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             col_inc,
  input  logic             row_inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_col,
  output logic             last_row
);

  assign last_col = (col == COL_W'(N_COL - 1));
  assign last_row = (row == ROW_W'(N_ROW - 1));

  // Both indices hold at their terminal values instead of wrapping.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (row_inc) begin
      col <= '0;
      if (!last_row) row <= row + 1'b1;
    end else if (col_inc && !last_col) begin
      col <= col + 1'b1;
    end
  end

endmodule

// File: rtl/img2col_window_sequencer.sv
// rtl/img2col_window_sequencer.sv - steps a KxK window over the feature map and drives PU/MAC handshakes
//   Ports: clk, nrst (async active-low); start frame pulse; pix_valid/pix_ready column
//   input handshake; pu_wr_en/pu_wr_addr group-buffer write; pu_rd_en/pu_round PU read
//   control; win_valid/win_ready with win_row/win_col window offer; busy; done pulse.
module img2col_window_sequencer
  import img2col_pkg::*;
#(
  parameter int KERNEL = 5,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int ADDR_W = 3
) (
  input  logic                                      clk,
  input  logic                                      nrst,
  input  logic                                      start,
  input  logic                                      pix_valid,
  output logic                                      pix_ready,
  output logic                                      pu_wr_en,
  output logic [ADDR_W-1:0]                         pu_wr_addr,
  output logic                                      pu_rd_en,
  output logic                                      pu_round,
  output logic                                      win_valid,
  input  logic                                      win_ready,
  output logic [idx_w(out_dim(IMG_H, KERNEL))-1:0]  win_row,
  output logic [idx_w(out_dim(IMG_W, KERNEL))-1:0]  win_col,
  output logic                                      busy,
  output logic                                      done
);

  localparam int OUT_W = out_dim(IMG_W, KERNEL);
  localparam int OUT_H = out_dim(IMG_H, KERNEL);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(KERNEL - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fill_cnt;
  logic              cnt_clr, col_inc, row_inc;
  logic              fill_clr, fill_inc;
  logic              round_set, round_clr;
  logic              last_col, last_row;

  img2col_win_counter #(
    .N_COL (OUT_W),
    .N_ROW (OUT_H)
  ) u_win_counter (
    .clk      (clk),
    .nrst     (nrst),
    .clr      (cnt_clr),
    .col_inc  (col_inc),
    .row_inc  (row_inc),
    .col      (win_col),
    .row      (win_row),
    .last_col (last_col),
    .last_row (last_row)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Every output except pu_wr_en is a decode of registered state, so the
  // column port and the window port are mutually exclusive by construction.
  always_comb begin
    state_nxt  = state;
    pix_ready  = 1'b0;
    pu_wr_addr = '0;
    pu_rd_en   = 1'b0;
    win_valid  = 1'b0;
    done       = 1'b0;
    cnt_clr    = 1'b0;
    col_inc    = 1'b0;
    row_inc    = 1'b0;
    fill_clr   = 1'b0;
    fill_inc   = 1'b0;
    round_set  = 1'b0;
    round_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          fill_clr  = 1'b1;
          round_set = 1'b1;
          state_nxt = FILL;
        end
      end
      FILL: begin
        pix_ready  = 1'b1;
        pu_wr_addr = fill_cnt;
        if (pix_valid) begin
          if (fill_cnt == LAST_SLOT) state_nxt = EMIT;
          else                       fill_inc  = 1'b1;
        end
      end
      EMIT: begin
        win_valid = 1'b1;
        pu_rd_en  = 1'b1;
        if (win_ready) begin
          if (!last_col) begin
            col_inc   = 1'b1;
            round_clr = 1'b1;
            state_nxt = SHIFT;
          end else if (!last_row) begin
            row_inc   = 1'b1;
            fill_clr  = 1'b1;
            round_set = 1'b1;
            state_nxt = FILL;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        // Only the newest slot is written; the PU ages the older columns itself.
        pix_ready  = 1'b1;
        pu_wr_addr = LAST_SLOT;
        if (pix_valid) state_nxt = EMIT;
      end
      DONE: begin
        done      = 1'b1;
        round_clr = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign pu_wr_en = pix_valid && pix_ready;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fill_cnt <= '0;
      pu_round <= 1'b0;
    end else begin
      if (fill_clr)      fill_cnt <= '0;
      else if (fill_inc) fill_cnt <= fill_cnt + 1'b1;
      if (round_set)      pu_round <= 1'b1;
      else if (round_clr) pu_round <= 1'b0;
    end
  end

endmodule

// File: tb/tb_img2col_window_sequencer.sv
// tb/tb_img2col_window_sequencer.sv - directed self-checking bench for img2col_window_sequencer
module tb_img2col_window_sequencer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       start;
  logic       pix_valid;
  logic       pix_ready;
  logic       pu_wr_en;
  logic [2:0] pu_wr_addr;
  logic       pu_rd_en;
  logic       pu_round;
  logic       win_valid;
  logic       win_ready;
  logic [0:0] win_row;
  logic [0:0] win_col;
  logic       busy;
  logic       done;

  int tests  = 0;
  int failed = 0;

  img2col_window_sequencer #(
    .KERNEL (5),
    .IMG_W  (6),
    .IMG_H  (6),
    .ADDR_W (3)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pu_wr_en   (pu_wr_en),
    .pu_wr_addr (pu_wr_addr),
    .pu_rd_en   (pu_rd_en),
    .pu_round   (pu_round),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_row    (win_row),
    .win_col    (win_col),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  wire [11:0] all_out = {pix_ready, pu_wr_en, pu_wr_addr, pu_rd_en, pu_round,
                         win_valid, win_row, win_col, busy, done};

  // Expected windows as {pu_round, row, col}, and the group-buffer write addresses.
  logic [2:0] exp_win [4]  = '{3'b100, 3'b001, 3'b110, 3'b011};
  int         exp_wr  [12] = '{0, 1, 2, 3, 4, 4, 0, 1, 2, 3, 4, 4};

  int         wr_q[$];
  logic [2:0] win_q[$];
  int         acc_cycle[$];
  int         done_cnt, done_cyc, busy_cnt, overlap, stall_bad, stall_seen;
  int         first_win_wr, idle_after, found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame from start; inputs change at negedge, outputs sampled 1ns later.
  task automatic run_frame(input bit toggle_pv, input bit stall, input bit inject);
    bit pv;
    int stall_left;
    wr_q.delete();
    win_q.delete();
    acc_cycle.delete();
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; overlap = 0;
    stall_bad = 0; stall_seen = 0; first_win_wr = -1; idle_after = 0;
    pv = 1'b0;
    stall_left = stall ? 7 : 0;
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b0; win_ready = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = inject && (win_valid || (pix_ready && !pu_round));
      pv = toggle_pv ? !pv : 1'b1;
      pix_valid = pv;
      if (stall && win_valid && win_row == 1'b0 && win_col == 1'b1 && stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
        stall_seen++;
      end else begin
        win_ready = 1'b1;
      end
      #1;
      if (!win_ready && (!win_valid || win_col !== 1'b1 || pix_ready || pu_wr_en)) stall_bad++;
      if (pu_wr_en) wr_q.push_back(int'(pu_wr_addr));
      if (win_valid && first_win_wr < 0) first_win_wr = wr_q.size();
      if (win_valid && win_ready) begin
        win_q.push_back({pu_round, win_row, win_col});
        acc_cycle.push_back(c);
      end
      if (pix_ready && win_valid) overlap++;
      if (busy && !done) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (done_cnt > 0 && c > done_cyc) begin
        idle_after = (busy === 1'b0 && done === 1'b0) ? 1 : 0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_busy);
    chk({tag, "_win_count"}, win_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_win%0d", tag, i), (i < win_q.size()) ? 32'(win_q[i]) : 32'hdead, 32'(exp_win[i]));
    chk({tag, "_wr_count"}, wr_q.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("%s_wr%0d", tag, i), (i < wr_q.size()) ? wr_q[i] : 32'hdead, exp_wr[i]);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    chk({tag, "_done_delay"}, (acc_cycle.size() == 4) ? done_cyc - acc_cycle[3] : -1, 1);
    chk({tag, "_overlap"}, overlap, 0);
    chk({tag, "_idle_after"}, idle_after, 1);
    chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
  endtask

  initial begin
    nrst = 1'b0; start = 1'b0; pix_valid = 1'b0; win_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'($urandom); pix_valid = 1'($urandom); win_ready = 1'($urandom);
      #1;
      chk("reset_outs", all_out, 0);
    end
    @(negedge clk);
    start = 1'b0; nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pix_valid = 1'($urandom); win_ready = 1'($urandom);
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_outs", all_out, 0);
    end

    run_frame(1'b0, 1'b0, 1'b0);
    check_frame("basic", 16);
    chk("basic_first_win_cycle", (acc_cycle.size() > 0) ? acc_cycle[0] : -1, 6);

    run_frame(1'b0, 1'b1, 1'b0);
    check_frame("stall", 23);
    chk("stall_cycles", stall_seen, 7);
    chk("stall_bad", stall_bad, 0);

    run_frame(1'b1, 1'b0, 1'b0);
    check_frame("gaps", 24);
    chk("gaps_writes_before_emit", first_win_wr, 5);
    chk("gaps_first_win_cycle", (acc_cycle.size() > 0) ? acc_cycle[0] : -1, 10);

    run_frame(1'b0, 1'b0, 1'b1);
    check_frame("inject", 16);

    run_frame(1'b0, 1'b0, 1'b0);
    check_frame("second", 16);

    found = 0;
    @(negedge clk);
    start = 1'b1; pix_valid = 1'b1; win_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (pix_ready && !pu_round && win_row == 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("rst_shift_found", found, 1);
    nrst = 1'b0;
    #1;
    chk("rst_async_outs", all_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("rst_hold_outs", all_out, 0);
    end
    @(negedge clk);
    nrst = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0);
    check_frame("after_rst", 16);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
